// File: rtl/liteeth_fifo_pkg.sv
// Shared defaults and pointer helper for the liteeth SRAM-backed stream FIFOs.
// Pointers wrap at DEPTH-1 explicitly, so DEPTH need not be a power of two.
package liteeth_fifo_pkg;

    localparam int FIFO_DATA_W = 32;
    localparam int FIFO_DEPTH  = 384;
    localparam int FIFO_ADDR_W = 9;
    localparam int FIFO_AFULL  = 320;

    typedef logic [FIFO_ADDR_W-1:0] fifo_addr_t;

    function automatic fifo_addr_t ptr_inc(input fifo_addr_t ptr, input int depth);
        return (int'(ptr) == depth - 1) ? '0 : ptr + fifo_addr_t'(1);
    endfunction

endpackage

// File: rtl/liteeth_fifo_outbuf.sv
// Two-entry output FIFO: registered head, zero-latency pop, push lands next cycle.
// Simultaneous push and pop are both honoured; a push into a full, unpopped buffer is dropped.
module liteeth_fifo_outbuf #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_vld,
    output logic [1:0]   o_cnt
);

    logic [W-1:0] r_mem [2];
    logic         r_head;
    logic [1:0]   r_cnt;
    logic         w_pop;
    logic         w_push;
    logic         w_tail;

    assign w_pop  = i_pop && (r_cnt != 2'd0);
    assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);
    // With two slots the tail is the head when count is 0 or 2, the other slot when 1.
    assign w_tail = r_head ^ r_cnt[0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_head <= 1'b0;
            r_cnt  <= 2'd0;
        end else if (i_flush) begin
            r_head <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) r_mem[w_tail] <= i_push_dat;
            if (w_pop)  r_head <= ~r_head;
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

    assign o_dat = r_mem[r_head];
    assign o_vld = (r_cnt != 2'd0);
    assign o_cnt = r_cnt;

endmodule

// File: rtl/liteeth_sram_fifo_ctrl.sv
// Stream FIFO over the 32x384 dual-port SRAM; empty-to-out_valid latency is 3 cycles, 1 word/cycle steady.
// in_ready drops when the SRAM holds DEPTH words; out side stalls cleanly on !out_ready.
module liteeth_sram_fifo_ctrl
    import liteeth_fifo_pkg::*;
#(
    parameter int DATA_W      = FIFO_DATA_W,
    parameter int DEPTH       = FIFO_DEPTH,
    parameter int ADDR_W      = FIFO_ADDR_W,
    parameter int AFULL_LEVEL = FIFO_AFULL
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [DATA_W-1:0] sram_din0,
    output logic              sram_csb1,
    output logic [ADDR_W-1:0] sram_addr1,
    input  logic [DATA_W-1:0] sram_dout1
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] L_AFULL = (ADDR_W+1)'(AFULL_LEVEL);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_mem_cnt;
    logic [ADDR_W:0]   r_level;
    logic              r_inflight;
    logic              r_afull;

    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic              w_cap;
    logic              w_ob_vld;
    logic [1:0]        w_ob_cnt;
    logic [1:0]        w_ob_nxt;
    logic [2:0]        w_ob_sum;
    logic [2:0]        w_ob_lim;
    logic [ADDR_W:0]   w_mem_nxt;
    logic [ADDR_W:0]   w_level_nxt;

    assign in_ready = (r_mem_cnt < L_DEPTH) && !flush;
    // in_ready reads high during reset, so the write strobe is gated by reset directly.
    assign w_push   = in_valid && in_ready && sys_rst_n;
    assign w_pop    = w_ob_vld && out_ready;

    // Issue only if the word can land in the output buffer once the current read returns.
    assign w_ob_sum = {1'b0, w_ob_cnt} + {2'b00, r_inflight};
    assign w_ob_lim = 3'd2 + {2'b00, w_pop};
    assign w_issue  = (r_mem_cnt != '0) && (w_ob_sum < w_ob_lim) && !flush;
    assign w_cap    = r_inflight && !flush;

    assign w_mem_nxt   = r_mem_cnt + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_issue);
    assign w_ob_nxt    = w_ob_cnt + 2'(w_cap) - 2'(w_pop);
    assign w_level_nxt = w_mem_nxt + (ADDR_W+1)'(w_issue) + (ADDR_W+1)'(w_ob_nxt);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
            r_level    <= '0;
            r_afull    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
            r_level    <= '0;
            r_afull    <= 1'b0;
        end else begin
            if (w_push)  r_wr_ptr <= ptr_inc(r_wr_ptr, DEPTH);
            if (w_issue) r_rd_ptr <= ptr_inc(r_rd_ptr, DEPTH);
            r_mem_cnt  <= w_mem_nxt;
            r_inflight <= w_issue;
            r_level    <= w_level_nxt;
            r_afull    <= (w_level_nxt >= L_AFULL);
        end
    end

    liteeth_fifo_outbuf #(
        .W(DATA_W)
    ) u_outbuf (
        .i_clk      (sys_clk),
        .i_rst_n    (sys_rst_n),
        .i_flush    (flush),
        .i_push     (w_cap),
        .i_push_dat (sram_dout1),
        .i_pop      (w_pop),
        .o_dat      (out_data),
        .o_vld      (w_ob_vld),
        .o_cnt      (w_ob_cnt)
    );

    assign out_valid   = w_ob_vld;
    assign level       = r_level;
    assign almost_full = r_afull;

    assign sram_csb0  = !w_push;
    assign sram_web0  = !w_push;
    assign sram_addr0 = r_wr_ptr;
    assign sram_din0  = in_data;
    assign sram_csb1  = !w_issue;
    assign sram_addr1 = r_rd_ptr;

endmodule
